control_sequencer: RTL

- Parametrised hardwired control unit that replaces per-instruction hand-written control FSMs.
- Drives every Datapath control input: fetch T0–T2, then an opcode-selected execute sequence T3–T7.
- Adds three capabilities:
  - configurable cycles per step;
  - memory wait-state handshake;
  - halt and illegal-opcode handling.
- Sits beside Datapath and takes the IR register output and CON FF as inputs.

---
 rtl/cpu_ctrl_pkg.sv | 86 ++++++++
 rtl/op_decoder.sv | 53 +++++
 rtl/control_sequencer.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the hardwired control sequencer: opcodes, ALU functions,
// instruction classes, sequencer states and the per-class final execute step.
package cpu_ctrl_pkg;

    localparam int unsigned OpLd   = 0;
    localparam int unsigned OpLdi  = 1;
    localparam int unsigned OpSt   = 2;
    localparam int unsigned OpAdd  = 3;
    localparam int unsigned OpSub  = 4;
    localparam int unsigned OpAnd  = 5;
    localparam int unsigned OpOr   = 6;
    localparam int unsigned OpShr  = 7;
    localparam int unsigned OpShl  = 8;
    localparam int unsigned OpRor  = 9;
    localparam int unsigned OpRol  = 10;
    localparam int unsigned OpAddi = 11;
    localparam int unsigned OpAndi = 12;
    localparam int unsigned OpOri  = 13;
    localparam int unsigned OpMul  = 14;
    localparam int unsigned OpDiv  = 15;
    localparam int unsigned OpNeg  = 16;
    localparam int unsigned OpNot  = 17;
    localparam int unsigned OpBr   = 18;
    localparam int unsigned OpJr   = 19;
    localparam int unsigned OpJal  = 20;
    localparam int unsigned OpIn   = 21;
    localparam int unsigned OpOut  = 22;
    localparam int unsigned OpMfhi = 23;
    localparam int unsigned OpMflo = 24;
    localparam int unsigned OpNop  = 25;
    localparam int unsigned OpHalt = 26;

    localparam logic [4:0] ALU_NOP = 5'd0;
    localparam logic [4:0] ALU_ADD = 5'd1;
    localparam logic [4:0] ALU_SUB = 5'd2;
    localparam logic [4:0] ALU_AND = 5'd3;
    localparam logic [4:0] ALU_OR  = 5'd4;
    localparam logic [4:0] ALU_SHR = 5'd5;
    localparam logic [4:0] ALU_SHL = 5'd6;
    localparam logic [4:0] ALU_ROR = 5'd7;
    localparam logic [4:0] ALU_ROL = 5'd8;
    localparam logic [4:0] ALU_MUL = 5'd9;
    localparam logic [4:0] ALU_DIV = 5'd10;
    localparam logic [4:0] ALU_NEG = 5'd11;
    localparam logic [4:0] ALU_NOT = 5'd12;

    typedef enum logic [3:0] {
        ClsNop, ClsLdi, ClsImm, ClsAlu, ClsMulDiv, ClsUnary, ClsLd, ClsSt,
        ClsBr, ClsJr, ClsJal, ClsMfhi, ClsMflo, ClsIn, ClsOut, ClsHalt
    } instr_cls_e;

    typedef enum logic [3:0] {
        StIdle, StT0, StT1, StT2, StT3, StT4, StT5, StT6, StT7, StHalt
    } state_e;

    typedef struct packed {
        logic mar;
        logic z;
        logic pc;
        logic mdr;
        logic ir;
        logic y;
        logic lo;
        logic hi;
        logic r_in;
        logic outport;
        logic con;
        logic ram_write;
        logic pc_inc;
    } wr_en_t;

    // Index of the last execute step; nop and illegal still spend one empty T3
    // because the IR is only loaded on the final edge of T2.
    function automatic logic [2:0] last_step(input instr_cls_e cls);
        logic [2:0] s;
        case (cls)
            ClsLdi, ClsImm, ClsAlu: s = 3'd5;
            ClsMulDiv, ClsBr:       s = 3'd6;
            ClsUnary, ClsJal:       s = 3'd4;
            ClsLd, ClsSt:           s = 3'd7;
            default:                s = 3'd3;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/op_decoder.sv
// Combinational opcode decoder: maps the IR opcode field onto an instruction
// class, the ALU function used by its compute step, and a legality flag.
module op_decoder
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned OPC_W = 5
) (
    input  logic [OPC_W-1:0] opcode_i,
    output instr_cls_e       cls_o,
    output logic [4:0]       alu_op_o,
    output logic             legal_o
);

    logic [31:0] opc;
    assign opc = 32'(opcode_i);

    always_comb begin
        cls_o    = ClsNop;
        alu_op_o = ALU_NOP;
        legal_o  = 1'b1;
        case (opc)
            OpLd:   begin cls_o = ClsLd;     alu_op_o = ALU_ADD; end
            OpLdi:  begin cls_o = ClsLdi;    alu_op_o = ALU_ADD; end
            OpSt:   begin cls_o = ClsSt;     alu_op_o = ALU_ADD; end
            OpAdd:  begin cls_o = ClsAlu;    alu_op_o = ALU_ADD; end
            OpSub:  begin cls_o = ClsAlu;    alu_op_o = ALU_SUB; end
            OpAnd:  begin cls_o = ClsAlu;    alu_op_o = ALU_AND; end
            OpOr:   begin cls_o = ClsAlu;    alu_op_o = ALU_OR;  end
            OpShr:  begin cls_o = ClsAlu;    alu_op_o = ALU_SHR; end
            OpShl:  begin cls_o = ClsAlu;    alu_op_o = ALU_SHL; end
            OpRor:  begin cls_o = ClsAlu;    alu_op_o = ALU_ROR; end
            OpRol:  begin cls_o = ClsAlu;    alu_op_o = ALU_ROL; end
            OpAddi: begin cls_o = ClsImm;    alu_op_o = ALU_ADD; end
            OpAndi: begin cls_o = ClsImm;    alu_op_o = ALU_AND; end
            OpOri:  begin cls_o = ClsImm;    alu_op_o = ALU_OR;  end
            OpMul:  begin cls_o = ClsMulDiv; alu_op_o = ALU_MUL; end
            OpDiv:  begin cls_o = ClsMulDiv; alu_op_o = ALU_DIV; end
            OpNeg:  begin cls_o = ClsUnary;  alu_op_o = ALU_NEG; end
            OpNot:  begin cls_o = ClsUnary;  alu_op_o = ALU_NOT; end
            OpBr:   begin cls_o = ClsBr;     alu_op_o = ALU_ADD; end
            OpJr:   cls_o = ClsJr;
            OpJal:  cls_o = ClsJal;
            OpIn:   cls_o = ClsIn;
            OpOut:  cls_o = ClsOut;
            OpMfhi: cls_o = ClsMfhi;
            OpMflo: cls_o = ClsMflo;
            OpNop:  cls_o = ClsNop;
            OpHalt: cls_o = ClsHalt;
            default: legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit: fetch T0-T2 then an opcode-selected execute sequence,
// with configurable cycles per step, memory wait states, halt and illegal opcodes.
module control_sequencer #(
    parameter int unsigned STEP_HOLD = 2,
    parameter int unsigned OPC_W     = 5,
    parameter int unsigned ALU_OP_W  = 5,
    parameter int unsigned MEM_WAIT  = 1
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                run,
    input  logic [31:0]         ir,
    input  logic                con_ff,
    input  logic                mem_ready,
    output logic                pc_out,
    output logic                zlo_out,
    output logic                zhi_out,
    output logic                hi_out,
    output logic                lo_out,
    output logic                mdr_out,
    output logic                inport_out,
    output logic                c_sign_extended_out,
    output logic                ba_out,
    output logic                r_out,
    output logic                mar_enable,
    output logic                z_enable,
    output logic                pc_enable,
    output logic                mdr_enable,
    output logic                ir_enable,
    output logic                y_enable,
    output logic                lo_enable,
    output logic                hi_enable,
    output logic                r_in,
    output logic                outport_enable,
    output logic                con_enable,
    output logic                read,
    output logic                ram_write,
    output logic                pc_increment,
    output logic                gra,
    output logic                grb,
    output logic                grc,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic [2:0]          step,
    output logic                halted,
    output logic                illegal
);
    import cpu_ctrl_pkg::*;

    localparam int unsigned    CntW    = (STEP_HOLD > 1) ? $clog2(STEP_HOLD) : 1;
    localparam logic [CntW-1:0] HoldMax = CntW'(STEP_HOLD - 1);

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    instr_cls_e cls;
    logic [4:0] dec_alu;
    logic       legal;

    op_decoder #(
        .OPC_W (OPC_W)
    ) u_op_decoder (
        .opcode_i (ir[31:32-OPC_W]),
        .cls_o    (cls),
        .alu_op_o (dec_alu),
        .legal_o  (legal)
    );

    logic unused_ir;
    assign unused_ir = ^ir[31-OPC_W:0];

    logic [3:0] st_raw;
    logic       in_t;
    logic [2:0] cur_step;
    logic       mem_step;
    logic       fin;
    logic       last;
    logic       fire;

    assign st_raw   = state_q;
    assign in_t     = (state_q != StIdle) && (state_q != StHalt);
    assign cur_step = in_t ? 3'(st_raw - 4'(StT0)) : 3'd0;
    assign mem_step = (state_q == StT1) || (state_q == StT6 && cls == ClsLd) ||
                      (state_q == StT7 && cls == ClsSt);
    // Final cycle of a step; memory steps additionally wait for mem_ready.
    assign fin      = in_t && (cnt_q == HoldMax) &&
                      (!mem_step || (MEM_WAIT == 0) || mem_ready);
    assign last     = (cur_step >= 3'd3) && (cur_step == last_step(cls));
    assign fire     = fin && !clr;

    always_ff @(posedge clk) begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (clr) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            case (state_q)
                StIdle: if (run) state_d = StT0;
                StHalt: state_d = StHalt;
                default: begin
                    if (fin) begin
                        cnt_d = '0;
                        if (last) begin
                            if (cls == ClsHalt) state_d = StHalt;
                            else                state_d = run ? StT0 : StIdle;
                        end else begin
                            state_d = state_e'(st_raw + 4'd1);
                        end
                    end else if (cnt_q != HoldMax) begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            endcase
        end
    end

    wr_en_t     we;
    logic [4:0] alu_sel;

    always_comb begin
        we                  = '0;
        alu_sel             = ALU_NOP;
        pc_out              = 1'b0;
        zlo_out             = 1'b0;
        zhi_out             = 1'b0;
        hi_out              = 1'b0;
        lo_out              = 1'b0;
        mdr_out             = 1'b0;
        inport_out          = 1'b0;
        c_sign_extended_out = 1'b0;
        ba_out              = 1'b0;
        r_out               = 1'b0;
        read                = 1'b0;
        gra                 = 1'b0;
        grb                 = 1'b0;
        grc                 = 1'b0;
        halted              = 1'b0;
        if (!clr) begin
            case (state_q)
                StT0: begin pc_out = 1'b1; we.mar = 1'b1; we.pc_inc = 1'b1; we.z = 1'b1; end
                StT1: begin zlo_out = 1'b1; read = 1'b1; we.pc = 1'b1; we.mdr = 1'b1; end
                StT2: begin mdr_out = 1'b1; we.ir = 1'b1; end
                StHalt: halted = 1'b1;
                StIdle: ;
                default: begin
                    case (cls)
                        ClsLdi, ClsImm, ClsLd, ClsSt: begin
                            case (cur_step)
                                3'd3: begin
                                    grb = 1'b1; we.y = 1'b1;
                                    if (cls == ClsImm) r_out = 1'b1;
                                    else               ba_out = 1'b1;
                                end
                                3'd4: begin
                                    c_sign_extended_out = 1'b1; alu_sel = dec_alu; we.z = 1'b1;
                                end
                                3'd5: begin
                                    zlo_out = 1'b1;
                                    if (cls == ClsLd || cls == ClsSt) begin
                                        we.mar = 1'b1;
                                    end else begin
                                        gra = 1'b1; we.r_in = 1'b1;
                                    end
                                end
                                3'd6: begin
                                    we.mdr = 1'b1;
                                    if (cls == ClsLd) read = 1'b1;
                                    else begin gra = 1'b1; r_out = 1'b1; end
                                end
                                3'd7: begin
                                    if (cls == ClsLd) begin
                                        mdr_out = 1'b1; gra = 1'b1; we.r_in = 1'b1;
                                    end else begin
                                        we.ram_write = 1'b1;
                                    end
                                end
                                default: ;
                            endcase
                        end
                        ClsAlu: begin
                            case (cur_step)
                                3'd3: begin grb = 1'b1; r_out = 1'b1; we.y = 1'b1; end
                                3'd4: begin
                                    grc = 1'b1; r_out = 1'b1; alu_sel = dec_alu; we.z = 1'b1;
                                end
                                3'd5: begin zlo_out = 1'b1; gra = 1'b1; we.r_in = 1'b1; end
                                default: ;
                            endcase
                        end
                        ClsMulDiv: begin
                            case (cur_step)
                                3'd3: begin gra = 1'b1; r_out = 1'b1; we.y = 1'b1; end
                                3'd4: begin
                                    grb = 1'b1; r_out = 1'b1; alu_sel = dec_alu; we.z = 1'b1;
                                end
                                3'd5: begin zlo_out = 1'b1; we.lo = 1'b1; end
                                3'd6: begin zhi_out = 1'b1; we.hi = 1'b1; end
                                default: ;
                            endcase
                        end
                        ClsUnary: begin
                            case (cur_step)
                                3'd3: begin
                                    grb = 1'b1; r_out = 1'b1; alu_sel = dec_alu; we.z = 1'b1;
                                end
                                3'd4: begin zlo_out = 1'b1; gra = 1'b1; we.r_in = 1'b1; end
                                default: ;
                            endcase
                        end
                        ClsBr: begin
                            case (cur_step)
                                3'd3: begin gra = 1'b1; r_out = 1'b1; we.con = 1'b1; end
                                3'd4: begin pc_out = 1'b1; we.y = 1'b1; end
                                3'd5: begin
                                    c_sign_extended_out = 1'b1; alu_sel = dec_alu; we.z = 1'b1;
                                end
                                3'd6: begin zlo_out = 1'b1; we.pc = con_ff; end
                                default: ;
                            endcase
                        end
                        ClsJr: if (cur_step == 3'd3) begin
                            gra = 1'b1; r_out = 1'b1; we.pc = 1'b1;
                        end
                        ClsJal: begin
                            case (cur_step)
                                3'd3: begin pc_out = 1'b1; grb = 1'b1; we.r_in = 1'b1; end
                                3'd4: begin gra = 1'b1; r_out = 1'b1; we.pc = 1'b1; end
                                default: ;
                            endcase
                        end
                        ClsMfhi: begin hi_out = 1'b1; gra = 1'b1; we.r_in = 1'b1; end
                        ClsMflo: begin lo_out = 1'b1; gra = 1'b1; we.r_in = 1'b1; end
                        ClsIn:   begin inport_out = 1'b1; gra = 1'b1; we.r_in = 1'b1; end
                        ClsOut:  begin gra = 1'b1; r_out = 1'b1; we.outport = 1'b1; end
                        default: ;
                    endcase
                end
            endcase
        end
    end

    assign mar_enable     = we.mar & fire;
    assign z_enable       = we.z & fire;
    assign pc_enable      = we.pc & fire;
    assign mdr_enable     = we.mdr & fire;
    assign ir_enable      = we.ir & fire;
    assign y_enable       = we.y & fire;
    assign lo_enable      = we.lo & fire;
    assign hi_enable      = we.hi & fire;
    assign r_in           = we.r_in & fire;
    assign outport_enable = we.outport & fire;
    assign con_enable     = we.con & fire;
    assign ram_write      = we.ram_write & fire;
    assign pc_increment   = we.pc_inc & fire;

    assign alu_op  = ALU_OP_W'(alu_sel);
    assign step    = clr ? 3'd0 : cur_step;
    assign illegal = !clr && (state_q == StT3) && (cnt_q == '0) && !legal;

endmodule
